apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Multi-requester APB master that shares a single APB bus (the `mst` side of the team's APB interface) between `N_REQ` internal requesters, such as the UVM-side register sequencer and on-chip config engines. It uses a round-robin arbiter and runs one complete APB transfer at a time: SETUP, then ACCESS with wait states. It returns read data and error status to the granted requester, and terminates hung transfers with a timeout.

## Interface
- `N_REQ`, default 2: number of requesters (≥2).
- `ADDR_W`, default `` `N_RBUS_ADDR_BITS ``: APB address width.
- `DATA_W`, default `` `N_RBUS_DATA_BITS ``: APB data width.
- `TIMEOUT`, default 256: maximum ACCESS cycles before forced termination (≥2).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester transfer request; held until accepted.
- `req_ready`  out  N_REQ  one-hot acceptance pulse.
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_write`  in  N_REQ  1 = write.
- `req_wdata`  in  N_REQ*DATA_W  packed write data.
- `rsp_valid`  out  N_REQ  one-hot completion pulse.
- `rsp_rdata`  out  DATA_W  read data; valid with `rsp_valid`.
- `rsp_err`  out  1  `pslverr` or timeout; valid with `rsp_valid`.
- `busy`  out  1  high in SETUP and ACCESS.
- `paddr`, `psel`, `penable`, `pwrite`, `pwdata`  out  ADDR_W/1/1/1/DATA_W  APB master outputs, all registered.
- `prdata`, `pready`, `pslverr`  in  DATA_W/1/1  APB slave responses.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any `req_valid` is high, grant g is the first set bit searching cyclically from `last_grant+1`.
  - `req_ready[g]` is driven combinationally high this cycle.
  - Address, write flag and write data are captured into the APB output registers.
  - `last_grant` ← g. Next state is SETUP.
  - `pwdata` is loaded with 0 for reads.
- **SETUP**: `psel`=1, `penable`=0 for exactly one cycle. Next state is ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1. The wait counter increments each cycle `pready`=0.
  - When `pready`=1:
    - Capture `prdata` for reads (0 for writes) and `pslverr`.
    - Register a `rsp_valid[g]` pulse for the next cycle.
    - Drop `psel`/`penable` and return to IDLE.
  - Timeout: if the counter reaches `TIMEOUT`-1 with `pready` still 0, terminate exactly as if `pready` had arrived, with `rsp_rdata`=0 and `rsp_err`=1.
- Round-robin fairness: after reset, `last_grant`=N_REQ-1, so requester 0 wins first. A requester that is continuously valid waits at most N_REQ-1 transfers.
- `paddr`, `pwrite` and `pwdata` hold their last values in IDLE. Only `psel` and `penable` return to 0.
- Exactly one `rsp_valid` bit is high per completed transfer. `rsp_rdata` and `rsp_err` hold until the next completion.
- Reset values:
  - all outputs 0
  - FSM in IDLE, wait counter 0, `last_grant`=N_REQ-1.
- Reset mid-transfer: outputs clear immediately (asynchronously) and no response is issued. The requester must re-issue.

## Timing
- Acceptance cycle T is in IDLE. SETUP is at T+1 and ACCESS at T+2.
- With zero wait states (`pready`=1 at T+2), `rsp_valid` is high at T+3 and the FSM is in IDLE at T+3. A new request may be accepted at T+3, giving 3 cycles per transfer minimum.
- Each wait state adds one cycle.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles, and `rsp_valid` follows the next cycle.
- A `req_valid` deasserted before acceptance is legal. The arbiter samples the live value only in IDLE.
- If `req_valid` is high for the granted requester while `rsp_valid` for that requester is high in the same cycle, it is a new request and is arbitrated normally.
- `pslverr` is sampled only when `pready`=1 in ACCESS.

## Test plan
- **Single read, requester 0, addr 0x10, slave returns 0xA5A5 with zero wait.**
  - `psel` rises at T+1, `penable` at T+2.
  - `rsp_valid`=2'b01 at T+3, `rsp_rdata`=0xA5A5, `rsp_err`=0.
- **Write from requester 1, addr 0x20, data 0x1234, slave inserts 3 wait states.**
  - `pwrite`=1 and `pwdata`=0x1234 stable through SETUP and ACCESS.
  - ACCESS lasts 4 cycles, then `rsp_valid`=2'b10.
- **Both requesters continuously valid for 4 transfers.**
  - Grant order 0, 1, 0, 1.
  - `req_ready` pulses are one-hot and spaced 3 cycles apart at zero wait.
- **Slave never asserts `pready`, `TIMEOUT`=8.**
  - ACCESS lasts 8 cycles.
  - `rsp_err`=1, `rsp_rdata`=0, `psel` falls, FSM returns to IDLE.
- **Slave returns `pslverr`=1 on a read.**
  - `rsp_err`=1 with the captured `prdata`. The next transfer clears `rsp_err` when it completes without error.
- **Assert `rst` during ACCESS.**
  - `psel`, `penable` and `busy` go to 0 immediately. No `rsp_valid`.
  - After release, requester 0 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master port among N_REQ requesters
`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 32
`endif
`ifndef N_RBUS_DATA_BITS
`define N_RBUS_DATA_BITS 32
`endif

module apb_req_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = `N_RBUS_ADDR_BITS,
    parameter int DATA_W  = `N_RBUS_DATA_BITS,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [ADDR_W-1:0]       paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W-1:0]       prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   g_next;
    logic            found;
    logic [CW-1:0]   wait_cnt;
    logic            done;

    // Cyclic search starting just after the previous winner.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        g_next = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                g_next = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst)
            req_ready[g_next] = 1'b1;
    end

    assign busy = (state != IDLE);
    assign done = pready || (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            wait_cnt   <= '0;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (found) begin
                        paddr      <= req_addr[int'(g_next)*ADDR_W +: ADDR_W];
                        pwrite     <= req_write[g_next];
                        pwdata     <= req_write[g_next] ? req_wdata[int'(g_next)*DATA_W +: DATA_W] : '0;
                        last_grant <= g_next;
                        psel       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        // A timed-out transfer reports an error with no data.
                        psel                  <= 1'b0;
                        penable               <= 1'b0;
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_rdata             <= (pready && !pwrite) ? prdata : '0;
                        rsp_err               <= pready ? pslverr : 1'b1;
                        wait_cnt              <= '0;
                        state                 <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #12;
        check("rst_psel", {31'd0, psel}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        check("rst_paddr", {16'd0, paddr}, 0);
        check("rst_req_ready", {30'd0, req_ready}, 0);
        step();
        rst = 1'b0;
        step();

        // Single read from requester 0, zero wait
        req_valid = 2'b01; req_addr[0 +: AW] = 16'h0010; req_write = 2'b00;
        pready = 1'b1; prdata = 16'hA5A5;
        #1 check("t1_ready", {30'd0, req_ready}, 2'b01);
        check("t1_idle_psel", {31'd0, psel}, 0);
        step(); req_valid = '0;
        check("t1_setup_psel", {31'd0, psel}, 1);
        check("t1_setup_pen", {31'd0, penable}, 0);
        check("t1_paddr", {16'd0, paddr}, 16'h0010);
        check("t1_busy", {31'd0, busy}, 1);
        step();
        check("t1_access_pen", {31'd0, penable}, 1);
        step();
        check("t1_rsp_valid", {30'd0, rsp_valid}, 2'b01);
        check("t1_rdata", {16'd0, rsp_rdata}, 16'hA5A5);
        check("t1_err", {31'd0, rsp_err}, 0);
        check("t1_psel_low", {31'd0, psel}, 0);

        // Write from requester 1 with 3 wait states
        req_valid = 2'b10; req_addr[AW +: AW] = 16'h0020; req_write = 2'b10;
        req_wdata[DW +: DW] = 16'h1234; pready = 1'b0;
        #1 check("t2_ready", {30'd0, req_ready}, 2'b10);
        step(); req_valid = '0;
        check("t2_setup_pwrite", {31'd0, pwrite}, 1);
        check("t2_setup_pwdata", {16'd0, pwdata}, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) pready = 1'b1;
            check("t2_access_pen", {31'd0, penable}, 1);
            check("t2_access_pwdata", {16'd0, pwdata}, 16'h1234);
            check("t2_access_rsp", {30'd0, rsp_valid}, 0);
        end
        step();
        check("t2_rsp_valid", {30'd0, rsp_valid}, 2'b10);
        check("t2_rdata", {16'd0, rsp_rdata}, 0);
        check("t2_pwrite_hold", {31'd0, pwrite}, 1);

        // Both requesters continuously valid: round-robin 0,1,0,1
        req_write = 2'b00; prdata = 16'h0001;
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            #1 check("t3_grant", {30'd0, req_ready}, (t % 2 == 0) ? 2'b01 : 2'b10);
            if (t > 0) check("t3_rsp", {30'd0, rsp_valid}, (t % 2 == 1) ? 2'b01 : 2'b10);
            step();
            check("t3_gap1", {30'd0, req_ready}, 0);
            step();
            check("t3_gap2", {30'd0, req_ready}, 0);
            step();
        end
        req_valid = '0;
        #1 check("t3_last_rsp", {30'd0, rsp_valid}, 2'b10);
        check("t3_no_grant", {30'd0, req_ready}, 0);

        // Timeout: slave never ready
        step();
        req_valid = 2'b01; req_addr[0 +: AW] = 16'h0030; pready = 1'b0; prdata = 16'hFFFF;
        step(); req_valid = '0;
        for (int i = 0; i < TO; i++) begin
            step();
            check("t4_access_pen", {31'd0, penable}, 1);
        end
        step();
        check("t4_rsp_valid", {30'd0, rsp_valid}, 2'b01);
        check("t4_err", {31'd0, rsp_err}, 1);
        check("t4_rdata", {16'd0, rsp_rdata}, 0);
        check("t4_psel", {31'd0, psel}, 0);
        check("t4_busy", {31'd0, busy}, 0);

        // pslverr on a read, then a clean read clears rsp_err
        req_valid = 2'b10; pready = 1'b1; pslverr = 1'b1; prdata = 16'hBEEF;
        step(); req_valid = '0;
        step(); step();
        check("t5_rsp_valid", {30'd0, rsp_valid}, 2'b10);
        check("t5_err", {31'd0, rsp_err}, 1);
        check("t5_rdata", {16'd0, rsp_rdata}, 16'hBEEF);
        pslverr = 1'b0; prdata = 16'h5555;
        step();
        check("t5_hold_err", {31'd0, rsp_err}, 1);
        check("t5_hold_rsp", {30'd0, rsp_valid}, 0);
        req_valid = 2'b01;
        step(); req_valid = '0;
        step(); step();
        check("t5_clean_err", {31'd0, rsp_err}, 0);
        check("t5_clean_rdata", {16'd0, rsp_rdata}, 16'h5555);

        // Reset asserted during ACCESS
        req_valid = 2'b10; req_write = 2'b10; pready = 1'b0;
        step(); req_valid = '0;
        step();
        check("t6_access_pen", {31'd0, penable}, 1);
        rst = 1'b1;
        #1 check("t6_psel", {31'd0, psel}, 0);
        check("t6_pen", {31'd0, penable}, 0);
        check("t6_busy", {31'd0, busy}, 0);
        step();
        check("t6_no_rsp", {30'd0, rsp_valid}, 0);
        rst = 1'b0;
        req_valid = 2'b11; req_write = 2'b00; pready = 1'b1;
        #1 check("t6_first_grant", {30'd0, req_ready}, 2'b01);
        step(); req_valid = '0;
        check("t6_paddr", {16'd0, paddr}, 16'h0030);
        step(); step();
        check("t6_rsp", {30'd0, rsp_valid}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
